vram_rect_writer: RTL and testbench

Write-side engine for the dual-port video RAM. It accepts rectangle-fill commands over a valid/ready handshake and drives VRAM port A (address, data, write enable) one pixel per clock, row-major. The display read path on port B consumes the result. It sits between the drawing/command logic and the VRAM write port. It runs on the same clock as the write port.

---
 rtl/vram_rect_writer.sv | 217 +++++++++++++++++++++
 tb/tb_vram_rect_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rect_writer.sv
// vram_rect_writer: rectangle-fill engine for VRAM write port A.
// It accepts one fill command at a time over cmd_valid/cmd_ready and then
// writes one pixel per clock in row-major order.
// Optional feature macro: VRAM_WR_CLIP_EN. When it is defined, pixels that
// fall outside the H_RES x V_RES frame are suppressed (vram_we=0), but their
// cycle is still used, so command timing is the same with or without it.
module vram_rect_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  output logic              vram_we,
  output logic              busy,
  output logic              done
);

  // Address math uses one extra bit so the sum cannot overflow before it
  // is truncated to the port width.
  localparam int AW1 = ADDR_W + 1;

`ifdef VRAM_WR_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Command fields captured at the accept edge.
  logic [9:0]        x_q;
  logic [9:0]        x_d;
  logic [8:0]        y_q;
  logic [8:0]        y_d;
  logic [9:0]        w_q;
  logic [9:0]        w_d;
  logic [8:0]        h_q;
  logic [8:0]        h_d;
  logic [DATA_W-1:0] color_q;
  logic [DATA_W-1:0] color_d;

  // Walk position within the rectangle and the linear address of the
  // current row's column 0.
  logic [9:0]        cx;
  logic [9:0]        cx_d;
  logic [8:0]        cy;
  logic [8:0]        cy_d;
  logic [AW1-1:0]    row_base;
  logic [AW1-1:0]    row_base_d;

  logic              accept;
  logic              zero_size;
  logic              last_col;
  logic              last_row;
  logic              load_pixel;
  logic              done_d;

  logic [10:0]       pix_col;
  logic [9:0]        pix_row;
  logic [AW1-1:0]    pix_addr;
  logic              in_frame;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              we_d;

  assign accept    = cmd_valid && cmd_ready;
  assign zero_size = (cmd_w == 10'd0) || (cmd_h == 9'd0);
  assign last_col  = (cx == (w_q - 10'd1));
  assign last_row  = (cy == (h_q - 9'd1));

  // State register; reset abandons any fill in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and walk control: latch the command, step columns, wrap rows.
  always_comb begin
    next_state = state;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    cx_d       = cx;
    cy_d       = cy;
    row_base_d = row_base;
    load_pixel = 1'b0;
    done_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          x_d        = cmd_x;
          y_d        = cmd_y;
          w_d        = cmd_w;
          h_d        = cmd_h;
          color_d    = cmd_color;
          cx_d       = '0;
          cy_d       = '0;
          row_base_d = AW1'(AW1'(cmd_y) * AW1'(H_RES));
          if (zero_size) begin
            next_state = ST_DONE;
            done_d     = 1'b1;
          end else begin
            next_state = ST_FILL;
            load_pixel = 1'b1;
          end
        end
      end

      ST_FILL: begin
        if (last_col) begin
          if (last_row) begin
            next_state = ST_DONE;
            done_d     = 1'b1;
          end else begin
            cx_d       = '0;
            cy_d       = cy + 9'd1;
            row_base_d = row_base + AW1'(H_RES);
            load_pixel = 1'b1;
          end
        end else begin
          cx_d       = cx + 10'd1;
          load_pixel = 1'b1;
        end
      end

      ST_DONE: begin
        next_state = ST_IDLE;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Address and frame test of the pixel that will be presented next cycle.
  always_comb begin
    pix_col  = {1'b0, x_d} + {1'b0, cx_d};
    pix_row  = {1'b0, y_d} + {1'b0, cy_d};
    pix_addr = row_base_d + AW1'(pix_col);
    in_frame = !CLIP_EN ||
               ((pix_col < 11'(H_RES)) && (pix_row < 10'(V_RES)));
  end

  // Port A values for next cycle; address and data hold when idle.
  always_comb begin
    addr_d = vram_addr;
    din_d  = vram_din;
    we_d   = 1'b0;
    if (load_pixel) begin
      addr_d = ADDR_W'(pix_addr);
      din_d  = color_d;
      we_d   = in_frame;
    end
  end

  // Registered datapath and outputs, so nothing on cmd_* reaches vram_* combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      cx        <= '0;
      cy        <= '0;
      row_base  <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      color_q   <= color_d;
      cx        <= cx_d;
      cy        <= cy_d;
      row_base  <= row_base_d;
      cmd_ready <= (next_state == ST_IDLE);
      busy      <= (next_state == ST_FILL);
      done      <= done_d;
      vram_we   <= we_d;
      vram_addr <= addr_d;
      vram_din  <= din_d;
    end
  end

endmodule

// File: tb/tb_vram_rect_writer.sv
// tb_vram_rect_writer: scoreboard bench for vram_rect_writer.
// Each accepted command is expanded by a pixel-list model into expected
// writes (address, colour, cycle) and an expected done cycle. A monitor
// compares these against port A and the done pulse at every falling edge.
module tb_vram_rect_writer;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x;
  logic [8:0]        cmd_y;
  logic [9:0]        cmd_w;
  logic [8:0]        cmd_h;
  logic [DATA_W-1:0] cmd_color;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_din;
  logic              vram_we;
  logic              busy;
  logic              done;

  vram_rect_writer #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .vram_addr(vram_addr),
    .vram_din (vram_din),
    .vram_we  (vram_we),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    longint unsigned addr;
    longint unsigned din;
    longint unsigned cyc;
  } wr_t;

  wr_t             exp_wr[$];
  longint unsigned exp_done[$];

  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;
  int unsigned cyc       = 0;
  int unsigned ready_exp = 0;

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; cyc seen at a falling edge names the cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint unsigned act,
                             input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic failNow(input string name);
    n_checks++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference model: enumerate the rectangle's pixels in row-major order.
  task automatic pushModel(input int unsigned x, input int unsigned y,
                           input int unsigned w, input int unsigned h,
                           input int unsigned color, input int unsigned k);
    int unsigned idx = 0;
    for (int unsigned r = 0; r < h; r++) begin
      for (int unsigned c = 0; c < w; c++) begin
        bit keep = 1'b1;
        longint unsigned lin;
        wr_t e;
        lin = longint'(y + r) * H_RES + x + c;
`ifdef VRAM_WR_CLIP_EN
        keep = ((x + c) < H_RES) && ((y + r) < V_RES);
`endif
        if (keep) begin
          e.addr = lin & ((64'd1 << ADDR_W) - 1);
          e.din  = color;
          e.cyc  = k + idx;
          exp_wr.push_back(e);
        end
        idx++;
      end
    end
    exp_done.push_back(k + w * h);
    ready_exp = k + w * h + 1;
  endtask

  task automatic idleGap(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Present one command, wait for acceptance, record its expectations.
  task automatic applyStimulus(input int unsigned x, input int unsigned y,
                               input int unsigned w, input int unsigned h,
                               input int unsigned color, input bit hold);
    int unsigned start = cyc;
    int unsigned n = 0;
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = 12'(color);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      failNow("ready_timeout");
      cmd_valid = 1'b0;
      return;
    end
    checkOutput("ready_cycle", cyc, (ready_exp > start) ? ready_exp : start);
    pushModel(x, y, w, h, color, cyc + 1);
    @(negedge clk);
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_x     = 10'($urandom);
      cmd_y     = 9'($urandom);
      cmd_w     = 10'($urandom);
      cmd_h     = 9'($urandom);
      cmd_color = 12'($urandom);
    end
  endtask

  // Monitor: pop and compare every write and every done pulse.
  always @(negedge clk) begin : monitor
    wr_t e;
    longint unsigned dc;
    if (vram_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        failNow("unexpected_write");
      end else begin
        e = exp_wr.pop_front();
        checkOutput("wr_addr", vram_addr, e.addr);
        checkOutput("wr_din", vram_din, e.din);
        checkOutput("wr_cycle", cyc, e.cyc);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        failNow("unexpected_done");
      end else begin
        dc = exp_done.pop_front();
        checkOutput("done_cycle", cyc, dc);
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int unsigned n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;

    // Reset values while rst is held
    @(negedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_we", vram_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_addr", vram_addr, 0);
    checkOutput("rst_din", vram_din, 0);
    rst = 1'b0;
    ready_exp = cyc + 1;

    // Directed cases
    applyStimulus(100, 100, 3, 2, 12'hF00, 1'b0);
    applyStimulus(0, 0, 1, 1, 12'h0AB, 1'b0);
    applyStimulus(0, 0, 0, 5, 12'h123, 1'b0);
    applyStimulus(638, 479, 4, 2, 12'h5A5, 1'b0);
    idleGap(2);

    // Back-to-back with cmd_valid held high
    applyStimulus(10, 20, 2, 1, 12'h111, 1'b1);
    applyStimulus(50, 60, 2, 1, 12'h222, 1'b0);

    // Reset in the middle of a 10x10 fill
    applyStimulus(5, 5, 10, 10, 12'h777, 1'b0);
    idleGap(4);
    checkOutput("busy_mid_fill", busy, 1);
    rst = 1'b1;
    exp_wr.delete();
    exp_done.delete();
    @(negedge clk);
    #1;
    checkOutput("midrst_we", vram_we, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_ready", cmd_ready, 0);
    rst = 1'b0;
    ready_exp = cyc + 1;
    applyStimulus(1, 2, 2, 2, 12'h9C3, 1'b0);

    // Randomized commands, some near the frame corner
    for (int i = 0; i < 24; i++) begin
      int unsigned x, y, w, h, c;
      bit hold;
      if (i % 4 == 3) begin
        x = $urandom_range(630, 639);
        y = $urandom_range(474, 479);
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      w = $urandom_range(0, 8);
      h = $urandom_range(0, 5);
      c = $urandom_range(0, 4095);
      hold = (i < 23) && ($urandom_range(0, 1) == 1);
      applyStimulus(x, y, w, h, c, hold);
      if (!hold) idleGap($urandom_range(0, 2));
    end

    // Drain the scoreboard
    n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0 || !cmd_ready) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain_writes", exp_wr.size(), 0);
    checkOutput("drain_done", exp_done.size(), 0);
    checkOutput("final_ready", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
